// File: rtl/regfile_pkg.sv
// Shared constants and types for the ARM-style three-port register file.
// Optional REGFILE_BYPASS_EN enables write-to-read forwarding in regfile_read_port.
package regfile_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 9;
    localparam int IDX_W         = 4;
    localparam int PC_OFFSET_DEF = 8;

    localparam logic [IDX_W-1:0] PC_IDX = 4'hF;

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: index decode, R15+offset substitution and,
// when REGFILE_BYPASS_EN is defined, forwarding of the in-flight write data.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_REGS  = 15,
    parameter int PC_OFFSET = PC_OFFSET_DEF
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_regs [NUM_REGS],
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_we,
    input  logic              i_rst_n,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [IDX_W-1:0] w_idx;
    logic             w_hit;
    logic             w_unused_addr;

    // Upper address bits are deliberately ignored so addresses alias modulo 16.
    assign w_idx         = i_addr[IDX_W-1:0];
    assign w_unused_addr = &{1'b0, i_addr[ADDR_W-1:IDX_W]};

`ifdef REGFILE_BYPASS_EN
    assign w_hit = i_we && i_rst_n && (i_widx != PC_IDX) && (w_idx == i_widx);
`else
    logic w_unused_bypass;
    assign w_hit           = 1'b0;
    assign w_unused_bypass = &{1'b0, i_we, i_rst_n, i_widx, i_wdata};
`endif

    // NOTE: every branch assigns o_rdata, so no latch is inferred.
    always_comb begin
        if (w_idx == PC_IDX) begin
            o_rdata = i_pc + DATA_W'(PC_OFFSET);
        end else if (w_hit) begin
            o_rdata = i_wdata;
        end else begin
            o_rdata = i_regs[w_idx];
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// Three-port register file R0..R14 with R15 reads returning the external PC + 8.
// Optional macro REGFILE_BYPASS_EN adds write-to-read forwarding on both ports.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_REGS  = 15,
    parameter int PC_OFFSET = PC_OFFSET_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic [DATA_W-1:0] R15,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [IDX_W-1:0]  w_widx;
    logic              w_unused_waddr;

    assign w_widx         = A3[IDX_W-1:0];
    assign w_unused_waddr = &{1'b0, A3[ADDR_W-1:IDX_W]};

    // NOTE: the storage array is reset because R0..R14 must read 0 during and after reset.
    // NOTE: non-blocking assignments keep same-edge reads and writes race-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (WE3 && (w_widx != PC_IDX)) begin
            r_regs[w_widx] <= WD3;
        end
    end

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .PC_OFFSET (PC_OFFSET)
    ) u_rd1 (
        .i_addr  (A1),
        .i_regs  (r_regs),
        .i_pc    (R15),
        .i_we    (WE3),
        .i_rst_n (rst),
        .i_widx  (w_widx),
        .i_wdata (WD3),
        .o_rdata (RD1)
    );

    regfile_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .PC_OFFSET (PC_OFFSET)
    ) u_rd2 (
        .i_addr  (A2),
        .i_regs  (r_regs),
        .i_pc    (R15),
        .i_we    (WE3),
        .i_rst_n (rst),
        .i_widx  (w_widx),
        .i_wdata (WD3),
        .o_rdata (RD2)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed plan followed by randomized
// traffic checked against an array-based reference model of the register file.
module tb_register_file;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  A1, A2, A3;
    logic [31:0] WD3, R15;
    logic        WE3;
    logic [31:0] RD1, RD2;

    int    n_vec = 0;
    int    n_err = 0;
    word_t model [16];

    register_file dut (
        .clk (clk),
        .rst (rst),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .WD3 (WD3),
        .WE3 (WE3),
        .R15 (R15),
        .RD1 (RD1),
        .RD2 (RD2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference read: PC + 8 for index 15, otherwise stored value or forwarded write data.
    function automatic word_t ref_read(input logic [8:0] a);
        int idx;
        idx = int'(a) % 16;
        if (idx == 15) return R15 + 32'd8;
`ifdef REGFILE_BYPASS_EN
        if (WE3 && rst && (int'(A3) % 16) != 15 && (int'(A3) % 16) == idx) return WD3;
`endif
        return model[idx];
    endfunction

    // Advance one clock edge, applying the write rule to the model at the edge.
    task automatic tick();
        @(posedge clk);
        if (WE3 && rst && (int'(A3) % 16) != 15) model[int'(A3) % 16] = WD3;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d);
        WE3 = 1'b1; A3 = a; WD3 = d;
        tick();
        WE3 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; R15 = '0;
        clear_model();

        // 1. Reset
        #12 rst = 1'b1;
        A1 = 9'd1; A2 = 9'd2; #1;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        tick();

        // 2. Write disabled
        WE3 = 1'b0; A3 = 9'd1; WD3 = 32'h12345678;
        tick();
        A1 = 9'd1; #1;
        check("we0_no_write", RD1, 32'h0);

        // 3. Write enabled
        do_write(9'd2, 32'h87654321);
        A2 = 9'd2; #1;
        check("write_rd2", RD2, 32'h87654321);
        A1 = 9'd2; #1;
        check("write_rd1", RD1, 32'h87654321);

        // 4. PC read, write to 15 discarded, modulo wrap
        R15 = 32'h00000010; A1 = 9'h00F; #1;
        check("pc_read", RD1, 32'h00000018);
        WE3 = 1'b1; A3 = 9'h00F; WD3 = 32'hDEADBEEF; #1;
        check("pc_no_bypass", RD1, 32'h00000018);
        tick();
        WE3 = 1'b0; #1;
        check("pc_write_ignored", RD1, 32'h00000018);
        R15 = 32'hFFFFFFFC; #1;
        check("pc_wrap", RD1, 32'h00000004);

        // 5. Asynchronous reset mid-cycle
        do_write(9'd14, 32'hCAFEF00D);
        A1 = 9'd2; A2 = 9'd14; #1;
        check("pre_reset_r2", RD1, 32'h87654321);
        check("pre_reset_r14", RD2, 32'hCAFEF00D);
        #2 rst = 1'b0; #1;
        clear_model();
        check("async_clr_r2", RD1, 32'h0);
        check("async_clr_r14", RD2, 32'h0);
        WE3 = 1'b1; A3 = 9'd5; WD3 = 32'h55555555; A1 = 9'd5; #1;
        check("reset_no_bypass", RD1, 32'h0);
        tick();
        rst = 1'b1; WE3 = 1'b0; #1;
        check("reset_write_blocked", RD1, 32'h0);

        // 6. Aliasing and bypass
        do_write(9'h013, 32'hA5A5A5A5);
        A1 = 9'h003; A2 = 9'h1F3; #1;
        check("alias_rd1", RD1, 32'hA5A5A5A5);
        check("alias_rd2", RD2, 32'hA5A5A5A5);
        WE3 = 1'b1; A3 = 9'd3; WD3 = 32'h5A5A5A5A; A1 = 9'd3; #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_before_edge", RD1, 32'h5A5A5A5A);
`else
        check("rdw_before_edge", RD1, 32'hA5A5A5A5);
`endif
        tick();
        WE3 = 1'b0; #1;
        check("rdw_after_edge", RD1, 32'h5A5A5A5A);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            A1  = 9'($urandom);
            A2  = ($urandom_range(0, 3) == 0) ? A1 : 9'($urandom);
            A3  = ($urandom_range(0, 2) == 0) ? A1 : 9'($urandom);
            WE3 = 1'($urandom);
            WD3 = $urandom;
            R15 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0; #1;
                clear_model();
                check("rnd_reset_rd1", RD1, ref_read(A1));
                #1 rst = 1'b1;
            end
            #1;
            check("rnd_rd1", RD1, ref_read(A1));
            check("rnd_rd2", RD2, ref_read(A2));
            tick();
            WE3 = 1'b0; #1;
            check("rnd_post_rd1", RD1, ref_read(A1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_register_file
